// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
// multi_debounce : per-channel synchroniser, counter debouncer, edge pulses
//                  and hold-to-repeat generator
// Revision       : 1.0
// ============================================================================
module multi_debounce #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 3000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                Reset_n,
  input  logic [CHANNELS-1:0] Button,
  output logic [CHANNELS-1:0] ButtonState,
  output logic [CHANNELS-1:0] Pressed,
  output logic [CHANNELS-1:0] Released,
  output logic [CHANNELS-1:0] Repeat,
  output logic                AnyPressed
);

  localparam logic        c_POL        = (ACTIVE_LOW != 0);
  localparam logic [15:0] c_DB_TERM    = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] c_DELAY_TERM = 26'(REPEAT_DELAY - 1);
  localparam logic [25:0] c_RATE_TERM  = 26'(REPEAT_RATE - 1);

  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_HOLD_WAIT = 2'd1;
  localparam logic [1:0] c_ST_REPEATING = 2'd2;

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  // Synchronisers reset to the raw unpressed level so no false edge follows reset.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= {CHANNELS{c_POL}};
      r_sync2 <= {CHANNELS{c_POL}};
    end else begin
      r_sync1 <= Button;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      AnyPressed <= 1'b0;
    end else begin
      AnyPressed <= |ButtonState;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic        w_level;
    logic        w_differ;
    logic        w_accept;
    logic        w_press;
    logic        w_release;
    logic [15:0] r_dbCnt;
    logic        r_state;
    logic        r_pressed;
    logic        r_released;

    assign w_level   = r_sync2[gi] ^ c_POL;
    assign w_differ  = (w_level != r_state);
    assign w_accept  = w_differ && (r_dbCnt == c_DB_TERM);
    assign w_press   = w_accept && !r_state;
    assign w_release = w_accept && r_state;

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
      if (!Reset_n) begin
        r_dbCnt    <= 16'd0;
        r_state    <= 1'b0;
        r_pressed  <= 1'b0;
        r_released <= 1'b0;
      end else begin
        r_pressed  <= w_press;
        r_released <= w_release;
        if (!w_differ || w_accept) begin
          r_dbCnt <= 16'd0;
        end else begin
          r_dbCnt <= r_dbCnt + 16'd1;
        end
        if (w_accept) begin
          r_state <= !r_state;
        end
      end
    end

    assign ButtonState[gi] = r_state;
    assign Pressed[gi]     = r_pressed;
    assign Released[gi]    = r_released;

    if (REPEAT_EN != 0) begin : g_repeat
      logic [1:0]  r_fsm;
      logic [1:0]  w_fsmNext;
      logic [25:0] r_rptCnt;
      logic [25:0] w_rptCntNext;
      logic        r_repeat;
      logic        w_repeatNext;

      always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
          r_fsm    <= c_ST_IDLE;
          r_rptCnt <= 26'd0;
          r_repeat <= 1'b0;
        end else begin
          r_fsm    <= w_fsmNext;
          r_rptCnt <= w_rptCntNext;
          r_repeat <= w_repeatNext;
        end
      end

      // Release wins over a coincident terminal count.
      always_comb begin
        w_fsmNext    = r_fsm;
        w_rptCntNext = r_rptCnt + 26'd1;
        case (r_fsm)
          c_ST_IDLE: begin
            w_rptCntNext = 26'd0;
            if (w_press) begin
              w_fsmNext = c_ST_HOLD_WAIT;
            end
          end
          c_ST_HOLD_WAIT: begin
            if (w_release) begin
              w_fsmNext    = c_ST_IDLE;
              w_rptCntNext = 26'd0;
            end else if (r_rptCnt == c_DELAY_TERM) begin
              w_fsmNext    = c_ST_REPEATING;
              w_rptCntNext = 26'd0;
            end
          end
          c_ST_REPEATING: begin
            if (w_release) begin
              w_fsmNext    = c_ST_IDLE;
              w_rptCntNext = 26'd0;
            end else if (r_rptCnt == c_RATE_TERM) begin
              w_rptCntNext = 26'd0;
            end
          end
          default: begin
            w_fsmNext    = c_ST_IDLE;
            w_rptCntNext = 26'd0;
          end
        endcase
      end

      always_comb begin
        w_repeatNext = 1'b0;
        if (!w_release) begin
          if (r_fsm == c_ST_HOLD_WAIT && r_rptCnt == c_DELAY_TERM) begin
            w_repeatNext = 1'b1;
          end else if (r_fsm == c_ST_REPEATING && r_rptCnt == c_RATE_TERM) begin
            w_repeatNext = 1'b1;
          end
        end
      end

      assign Repeat[gi] = r_repeat;
    end else begin : g_noRepeat
      assign Repeat[gi] = 1'b0;
    end
  end

endmodule
`default_nettype wire
